// File: rtl/gait_sequencer.sv
// rtl/gait_sequencer.sv - programmable-period step divider driving a 4-phase wave gait onto the leg enables
module gait_sequencer #(
  parameter int DIV_W = 24,
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [DIV_W-1:0] period,
  input  logic [CYC_W-1:0] cycles,
  output logic             busy,
  output logic             step_tick,
  output logic [1:0]       phase,
  output logic [3:0]       legs,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] period_q, step_cnt;
  logic [CYC_W-1:0] cycles_q, cyc_cnt;
  logic             dir_q, stop_pend;
  logic             boundary, terminal, finish;
  logic [1:0]       next_phase, phase_d;
  logic [3:0]       legs_d;
  logic             busy_d, tick_d, done_d;

  function automatic logic [3:0] pattern(input logic [1:0] ph);
    case (ph)
      2'd0:    pattern = 4'b1001;
      2'd1:    pattern = 4'b1100;
      2'd2:    pattern = 4'b0110;
      default: pattern = 4'b0011;
    endcase
  endfunction

  // A run can only end on the boundary that wraps the gait back to phase 0.
  always_comb begin
    boundary   = (state_q == RUN) && (step_cnt == period_q - DIV_W'(1));
    next_phase = dir_q ? phase + 2'd1 : phase - 2'd1;
    terminal   = boundary && (next_phase == 2'd0);
    finish     = terminal && (stop_pend || stop ||
                 ((cycles_q != '0) && (cyc_cnt + CYC_W'(1) == cycles_q)));
    state_d    = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_d == RUN);
    phase_d = phase;
    if (state_d == IDLE || state_q == IDLE)
      phase_d = 2'd0;
    else if (boundary)
      phase_d = next_phase;
    legs_d  = busy_d ? pattern(phase_d) : 4'b0000;
    tick_d  = (state_q == RUN) && (state_d == RUN) && boundary;
    done_d  = (state_q == RUN) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      step_tick <= 1'b0;
      phase     <= 2'd0;
      legs      <= 4'b0000;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      step_tick <= tick_d;
      phase     <= phase_d;
      legs      <= legs_d;
      done      <= done_d;
    end
  end

  // Run configuration is frozen at start; period below 2 cannot form a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q  <= '0;
      cycles_q  <= '0;
      dir_q     <= 1'b0;
      step_cnt  <= '0;
      cyc_cnt   <= '0;
      stop_pend <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        period_q  <= (period < DIV_W'(2)) ? DIV_W'(2) : period;
        cycles_q  <= cycles;
        dir_q     <= dir;
        step_cnt  <= '0;
        cyc_cnt   <= '0;
        stop_pend <= 1'b0;
      end
    end else begin
      step_cnt  <= boundary ? '0 : step_cnt + DIV_W'(1);
      stop_pend <= stop_pend | stop;
      if (terminal && !finish)
        cyc_cnt <= cyc_cnt + CYC_W'(1);
    end
  end

endmodule

// File: tb/tb_gait_sequencer.sv
// tb/tb_gait_sequencer.sv - vector table, directed scenarios and random runs against a timeline model
module tb_gait_sequencer;
  localparam int DIV_W = 24;
  localparam int CYC_W = 8;

  logic             clk = 1'b0;
  logic             rst, start, stop, dir;
  logic [DIV_W-1:0] period;
  logic [CYC_W-1:0] cycles;
  logic             busy, step_tick, done;
  logic [1:0]       phase;
  logic [3:0]       legs;
  logic [8:0]       dut_out;

  int checks = 0;
  int errors = 0;

  gait_sequencer #(.DIV_W(DIV_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
    .period(period), .cycles(cycles), .busy(busy), .step_tick(step_tick),
    .phase(phase), .legs(legs), .done(done)
  );

  always #5 clk = ~clk;
  assign dut_out = {busy, step_tick, phase, legs, done};

  // Model: a run is a timeline of n cycles since busy rose; it lasts 4*p*G cycles.
  bit m_run, m_done, m_dir;
  int m_n, m_p, m_g, m_stopg;

  function automatic logic [3:0] leg_table(input logic [1:0] ph);
    logic [3:0] t [4];
    t[0] = 4'b1001; t[1] = 4'b1100; t[2] = 4'b0110; t[3] = 4'b0011;
    return t[ph];
  endfunction

  task automatic model_edge();
    int lim;
    if (rst) begin
      m_run = 0; m_done = 0;
    end else if (!m_run) begin
      m_done = 0;
      if (start) begin
        m_run = 1; m_n = 0; m_dir = dir; m_stopg = 0;
        m_p = (period < 2) ? 2 : int'(period);
        m_g = int'(cycles);
      end
    end else begin
      if (stop && m_stopg == 0) m_stopg = m_n / (4 * m_p) + 1;
      lim = m_g;
      if (m_stopg != 0 && (lim == 0 || m_stopg < lim)) lim = m_stopg;
      if (lim != 0 && m_n + 1 == 4 * m_p * lim) begin
        m_run = 0; m_done = 1;
      end else begin
        m_n++; m_done = 0;
      end
    end
  endtask

  function automatic logic [8:0] model_out();
    int s;
    logic [1:0] ph;
    if (!m_run) return {1'b0, 1'b0, 2'b00, 4'b0000, m_done};
    s  = m_n / m_p;
    ph = m_dir ? 2'(s % 4) : 2'((4 - s % 4) % 4);
    return {1'b1, (m_n > 0 && m_n % m_p == 0), ph, leg_table(ph), 1'b0};
  endfunction

  task automatic drive(input logic r, s, sp, d, input int per, input int cyc);
    rst = r; start = s; stop = sp; dir = d;
    period = DIV_W'(per); cycles = CYC_W'(cyc);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, s, sp, d, input int per, input int cyc, input string name);
    logic [8:0] exp;
    drive(r, s, sp, d, per, cyc);
    exp = model_out();
    checks++;
    if (dut_out !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (busy,tick,phase,legs,done)", name, dut_out, exp);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_measure(input int per, input int cyc, input logic d, input logic sp,
                             output int ticks, output int done_at, output int done_cnt);
    ticks = 0; done_at = -1; done_cnt = 0;
    step(0, 1, sp, d, per, cyc, "run_start");
    for (int i = 1; i <= 120; i++) begin
      step(0, 0, 0, d, per, cyc, "run_cycle");
      if (step_tick) ticks++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
  endtask

  typedef struct {
    logic       r, s, sp, d;
    int         per, cyc;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int tk, da, dc, guard;
    rst = 1; start = 0; stop = 0; dir = 1; period = '0; cycles = '0;

    // {busy, tick, phase, legs, done}
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 9'b0_0_00_0000_0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 9'b1_0_00_1001_0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9, 1, 9'b1_0_00_1001_0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9, 1, 9'b1_1_01_1100_0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9, 1, 9'b1_0_01_1100_0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9, 1, 9'b1_1_10_0110_0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9, 1, 9'b1_0_10_0110_0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 9, 1, 9'b1_1_11_0011_0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 9, 1, 9'b1_0_11_0011_0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 9, 1, 9'b0_0_00_0000_1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 9'b1_0_00_1001_0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 5, 0, 9'b1_0_00_1001_0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 5, 0, 9'b1_1_11_0011_0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 5, 0, 9'b0_0_00_0000_0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 5, 0, 9'b0_0_00_0000_0};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].sp, tbl[i].d, tbl[i].per, tbl[i].cyc);
      checks++;
      if (dut_out !== tbl[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got %b expected %b", i, dut_out, tbl[i].exp);
      end
    end

    run_measure(5, 1, 1'b1, 1'b0, tk, da, dc);
    chk("fwd_ticks", tk, 3); chk("fwd_done_lat", da, 20); chk("fwd_done_cnt", dc, 1);

    run_measure(3, 2, 1'b0, 1'b0, tk, da, dc);
    chk("rev_ticks", tk, 7); chk("rev_done_lat", da, 24);

    run_measure(0, 1, 1'b1, 1'b0, tk, da, dc);
    chk("clamp_ticks", tk, 3); chk("clamp_done_lat", da, 8);

    run_measure(2, 2, 1'b1, 1'b1, tk, da, dc);
    chk("startstop_ticks", tk, 7); chk("startstop_done_lat", da, 16);

    // Reset while phase 2 is showing, then a clean rerun.
    step(0, 1, 0, 1, 4, 1, "rst_start");
    guard = 0;
    while (phase != 2'd2 && guard < 50) begin
      step(0, 0, 0, 1, 4, 1, "rst_run");
      guard++;
    end
    chk("rst_reached_phase2", int'(phase), 2);
    step(1, 0, 0, 1, 4, 1, "rst_apply");
    chk("rst_outputs", int'(dut_out), 0);
    step(0, 0, 0, 1, 4, 1, "rst_idle");
    run_measure(5, 1, 1'b1, 1'b0, tk, da, dc);
    chk("rerun_ticks", tk, 3); chk("rerun_done_lat", da, 20);

    // Continuous run: stop during phase 2 of the third gait, with start pulses and a dir flip.
    step(0, 1, 0, 1, 4, 0, "cont_start");
    da = -1;
    for (int i = 1; i <= 80; i++) begin
      step(0, (i % 5) == 0, i == 41, (i > 10) ? 1'b0 : 1'b1, 7, 3, "cont_run");
      if (done && da < 0) da = i;
    end
    chk("cont_done_lat", da, 48);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           1'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gait_sequencer.md
Name: gait_sequencer

Overview:
- Step scheduler for the crab leg drive. Contains a programmable-period step divider and sequences a fixed 4-phase wave-gait pattern onto the leg enable lines.
- Replaces fixed-rate bit pumps. Rate, direction and gait-cycle count are configured per run.
- Sits between the behaviour logic (start/stop/dir commands) and the leg motor drivers.

Parameters:
- DIV_W, 24: width of the period input and of the internal step counter.
- CYC_W, 8: width of the cycles input and of the internal gait-cycle counter.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request to begin a run; sampled only in IDLE.
- stop, input, 1: one-cycle graceful stop request; sampled only in RUN.
- dir, input, 1: 1 = forward, 0 = reverse; latched at start.
- period, input, DIV_W: clk cycles per step; latched at start.
- cycles, input, CYC_W: number of full gait cycles; 0 = continuous; latched at start.
- busy, output, 1: high while in RUN.
- step_tick, output, 1: one-cycle pulse coincident with each phase/legs change.
- phase, output, 2: current gait phase.
- legs, output, 4: leg enable pattern.
- done, output, 1: one-cycle pulse when a run terminates.

Behaviour:
- Reset: on rst=1 at a clk edge, the block goes to IDLE. busy=0, step_tick=0, done=0, phase=0, legs=0, and all counters are 0.
- rst overrides every other input, including mid-run. No done pulse is generated on reset.
- All outputs are registered.
- Pattern table (phase -> legs): 0 -> 1001, 1 -> 1100, 2 -> 0110, 3 -> 0011.
- States: IDLE and RUN.
- IDLE: busy=0, legs=0, phase=0. stop is ignored.
  - start=1 at edge k latches period_q, dir_q and cycles_q.
  - period_q = max(period, 2); values 0 and 1 clamp to 2.
  - At edge k it also clears step_cnt, cyc_cnt and stop_pend.
  - From k+1: busy=1, phase=0, legs=1001. No step_tick on entry.
  - start and stop asserted together in IDLE: start is accepted, stop is ignored.
- RUN:
  - start is ignored. dir, period and cycles changes have no effect until the next run.
  - step_cnt increments every cycle. At step_cnt == period_q-1 it wraps to 0: a step boundary.
  - At a step boundary, forward steps phase 0,1,2,3,0 and reverse steps 0,3,2,1,0.
  - step_tick=1 for exactly the cycle in which the new phase/legs is first visible.
  - First step_tick occurs period_q cycles after busy rises. Consecutive ticks are period_q cycles apart.
  - A boundary whose next phase would be 0 ends a gait cycle. Call it the terminal boundary.
- Terminal boundary:
  - If stop_pend=1, or (cycles_q != 0 and cyc_cnt+1 == cycles_q), the block returns to IDLE.
  - Next cycle: busy=0, legs=0, phase=0, done=1 for one cycle, step_tick=0.
  - Otherwise cyc_cnt increments (wrapping in continuous mode), phase goes to 0, and step_tick pulses.
- stop in RUN sets stop_pend. The run always ends on a gait-cycle boundary; it is never cut mid-gait.
  - stop on the same edge as the terminal boundary takes effect at that boundary.
- cycles=0 runs until stop or rst. Max finite run is 2^CYC_W-1 gait cycles.
- start on the same edge that done is generated is ignored (block still in RUN). start one cycle later is accepted.

Test Plan:
- Forward single cycle: rst; period=5, cycles=1, dir=1, start at t.
  -> busy=1 and legs=1001 from t+1; step_tick with legs 1100 at t+6, 0110 at t+11, 0011 at t+16.
  -> done=1, busy=0, legs=0 at t+21, no step_tick there; done exactly 1 cycle.
- Reverse two cycles: period=3, cycles=2, dir=0.
  -> phases 0,3,2,1,0,3,2,1 every 3 cycles; 7 step_ticks; done 24 cycles after busy rises.
- Clamp: period=0, cycles=1.
  -> steps every 2 cycles; done 8 cycles after busy rises.
- Continuous with graceful stop: period=4, cycles=0; pulse stop while phase=2 in the 3rd gait cycle.
  -> phases 3 then terminal; done at the end of that gait cycle; legs never glitch.
  -> start pulses during RUN are ignored, and a dir flip mid-run does not change direction.
- Reset mid-run: rst=1 while phase=2.
  -> next cycle busy=0, legs=0, phase=0, no done.
  -> a new start then behaves exactly as in the first scenario.
- Simultaneous start+stop in IDLE: start accepted, run completes its full cycles count.
  -> start on the done edge is ignored; start one cycle after done is accepted.
